// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath strobes and clock-gate enables, and faults on a stalled memory handshake.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             clear_fault,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_sel,
  output logic             rf_read_en,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_write_en,
  output logic             wb_sel,
  output logic [3:0]       cg_en,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retire_count
);

  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    FAULT   = 3'd6
  } state_t;

  state_t          state;
  logic [6:0]      op_q;
  logic [WW-1:0]   wait_cnt;

  logic known, is_rtype, is_load, is_store, is_branch, timeout_hit, retire;

  // Opcode classification, retire detection and timeout comparison.
  always_comb begin
    known       = (opcode == OP_RTYPE) || (opcode == OP_LOAD) ||
                  (opcode == OP_STORE) || (opcode == OP_BRANCH);
    is_rtype    = (op_q == OP_RTYPE);
    is_load     = (op_q == OP_LOAD);
    is_store    = (op_q == OP_STORE);
    is_branch   = (op_q == OP_BRANCH);
    timeout_hit = (MEM_TIMEOUT != 0) && (32'(wait_cnt) == MEM_TIMEOUT - 1);
    retire      = ((state == DECODE)  && !known) ||
                  ((state == EXECUTE) && is_branch) ||
                  ((state == MEM)     && is_store && dmem_ready) ||
                  (state == WB);
  end

  // State sequencing, wait counter, opcode latch and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= 7'd0;
      wait_cnt     <= '0;
      retire_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            wait_cnt <= '0;
          end
        end
        FETCH: begin
          if (imem_ready) state <= DECODE;
          else if (timeout_hit) state <= FAULT;
          else wait_cnt <= wait_cnt + WW'(1);
        end
        DECODE: begin
          op_q <= opcode;
          if (known) state <= EXECUTE;
        end
        EXECUTE: begin
          if (is_rtype) state <= WB;
          else if (is_load || is_store) begin
            state    <= MEM;
            wait_cnt <= '0;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            if (is_load) state <= WB;
          end else if (timeout_hit) state <= FAULT;
          else wait_cnt <= wait_cnt + WW'(1);
        end
        WB: begin
          state <= WB;
        end
        FAULT: begin
          if (clear_fault) state <= IDLE;
        end
        default: state <= FAULT;
      endcase
      // An instruction boundary overrides the per-state next state above.
      if (retire) begin
        retire_count <= retire_count + CNT_W'(1);
        state        <= halt ? IDLE : FETCH;
        wait_cnt     <= '0;
      end
    end
  end

  // Strobes decoded from the state register, gated by same-cycle conditions.
  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_sel      = 1'b0;
    rf_read_en  = 1'b0;
    alu_en      = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_write_en = 1'b0;
    wb_sel      = 1'b0;
    cg_en       = 4'b0000;
    busy        = (state != IDLE) && (state != FAULT);
    fault       = (state == FAULT);
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
        cg_en    = 4'b0001;
      end
      DECODE: begin
        rf_read_en = 1'b1;
        pc_load    = !known;
        cg_en      = 4'b0010;
      end
      EXECUTE: begin
        alu_en  = 1'b1;
        pc_load = is_branch;
        pc_sel  = is_branch && branch_taken;
        cg_en   = 4'b0100;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        pc_load  = is_store && dmem_ready;
        cg_en    = 4'b1000;
      end
      WB: begin
        rf_write_en = 1'b1;
        wb_sel      = is_load;
        pc_load     = 1'b1;
        cg_en       = 4'b0010;
      end
      default: begin
        cg_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; per-cycle output vectors are hand-computed.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, halt, clear_fault, branch_taken, imem_ready, dmem_ready;
  logic [6:0]  opcode;
  logic        imem_req, ir_load, pc_load, pc_sel, rf_read_en, alu_en, dmem_req, dmem_we;
  logic        rf_write_en, wb_sel, busy, fault;
  logic [3:0]  cg_en;
  logic [15:0] retire_count;
  logic [15:0] outv;

  int checks = 0;
  int errors = 0;

  // Output vector layout:
  // [15]imem_req [14]ir_load [13]pc_load [12]pc_sel [11]rf_read_en [10]alu_en [9]dmem_req
  // [8]dmem_we [7]rf_write_en [6]wb_sel [5:2]cg_en [1]busy [0]fault
  localparam logic [15:0] V_IDLE    = 16'h0000;
  localparam logic [15:0] V_FETCH   = 16'hC006;
  localparam logic [15:0] V_DEC     = 16'h080A;
  localparam logic [15:0] V_DEC_NOP = 16'h280A;
  localparam logic [15:0] V_EXE     = 16'h0412;
  localparam logic [15:0] V_EXE_BT  = 16'h3412;
  localparam logic [15:0] V_EXE_BN  = 16'h2412;
  localparam logic [15:0] V_MEM_LD  = 16'h0222;
  localparam logic [15:0] V_MEM_ST  = 16'h0322;
  localparam logic [15:0] V_WB_R    = 16'h208A;
  localparam logic [15:0] V_WB_LD   = 16'h20CA;
  localparam logic [15:0] V_FAULT   = 16'h0001;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  assign outv = {imem_req, ir_load, pc_load, pc_sel, rf_read_en, alu_en, dmem_req, dmem_we,
                 rf_write_en, wb_sel, cg_en, busy, fault};

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear_fault(clear_fault),
    .opcode(opcode), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load),
    .pc_sel(pc_sel), .rf_read_en(rf_read_en), .alu_en(alu_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .rf_write_en(rf_write_en), .wb_sel(wb_sel), .cg_en(cg_en),
    .busy(busy), .fault(fault), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check_eq(tag, {16'd0, outv}, {16'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; clear_fault = 1'b0; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_R;
    #12;
    check_eq("reset_outputs", {16'd0, outv}, 32'd0);
    check_eq("reset_count", {16'd0, retire_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // R-type: 4 cycles, then back in FETCH
    step("idle_pre", V_IDLE);
    start = 1'b1;
    step("idle_start", V_IDLE);
    start = 1'b0;
    step("r_fetch", V_FETCH);
    step("r_decode", V_DEC);
    step("r_exe", V_EXE);
    step("r_wb", V_WB_R);
    check_eq("r_count", {16'd0, retire_count}, 32'd1);
    step("r_refetch", V_FETCH);

    // Load with two dmem wait cycles: 7 cycles total
    opcode = OP_LD; dmem_ready = 1'b0;
    step("ld_decode", V_DEC);
    step("ld_exe", V_EXE);
    step("ld_mem_w1", V_MEM_LD);
    step("ld_mem_w2", V_MEM_LD);
    dmem_ready = 1'b1;
    step("ld_mem_rdy", V_MEM_LD);
    step("ld_wb", V_WB_LD);
    check_eq("ld_count", {16'd0, retire_count}, 32'd2);

    // Branch taken then not taken: 3 cycles each
    opcode = OP_BR; branch_taken = 1'b1;
    step("bt_fetch", V_FETCH);
    step("bt_decode", V_DEC);
    step("bt_exe", V_EXE_BT);
    check_eq("bt_count", {16'd0, retire_count}, 32'd3);
    branch_taken = 1'b0;
    step("bn_fetch", V_FETCH);
    step("bn_decode", V_DEC);
    step("bn_exe", V_EXE_BN);
    check_eq("bn_count", {16'd0, retire_count}, 32'd4);

    // Store with dmem stuck low: 15 MEM cycles then FAULT
    opcode = OP_ST; dmem_ready = 1'b0; start = 1'b1;
    step("st_fetch", V_FETCH);
    start = 1'b0;
    step("st_decode", V_DEC);
    step("st_exe", V_EXE);
    for (int i = 0; i < 15; i++) step($sformatf("st_mem_%0d", i), V_MEM_ST);
    step("fault_1", V_FAULT);
    step("fault_hold", V_FAULT);
    clear_fault = 1'b1;
    step("fault_clear", V_FAULT);
    clear_fault = 1'b0;
    step("after_clear", V_IDLE);
    check_eq("fault_count", {16'd0, retire_count}, 32'd4);

    // Halt during WB returns to IDLE
    dmem_ready = 1'b1; opcode = OP_R; start = 1'b1;
    step("h_idle", V_IDLE);
    start = 1'b0;
    step("h_fetch", V_FETCH);
    step("h_decode", V_DEC);
    step("h_exe", V_EXE);
    halt = 1'b1;
    step("h_wb", V_WB_R);
    halt = 1'b0;
    step("h_idle_after", V_IDLE);
    step("h_idle_stay", V_IDLE);
    check_eq("h_count", {16'd0, retire_count}, 32'd5);

    // Unknown opcode retires from DECODE in 2 cycles
    opcode = 7'b1111111; start = 1'b1;
    step("nop_idle", V_IDLE);
    start = 1'b0;
    step("nop_fetch", V_FETCH);
    step("nop_decode", V_DEC_NOP);
    check_eq("nop_count", {16'd0, retire_count}, 32'd6);
    step("nop_refetch", V_FETCH);

    // Asynchronous reset during MEM
    opcode = OP_LD; dmem_ready = 1'b0;
    step("rs_decode", V_DEC);
    step("rs_exe", V_EXE);
    step("rs_mem", V_MEM_LD);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rs_outputs", {16'd0, outv}, 32'd0);
    check_eq("rs_count", {16'd0, retire_count}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1; dmem_ready = 1'b1;
    @(posedge clk); #1;
    step("rs_idle_1", V_IDLE);
    step("rs_idle_2", V_IDLE);
    start = 1'b1;
    step("rs_start", V_IDLE);
    start = 1'b0;
    step("rs_fetch", V_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RISC-V core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and drives the datapath strobes and per-unit clock-gate enables. It also handles the ready handshakes to instruction and data memory, with a bounded wait on each. It sits between the instruction register / memories and the datapath, taking over sequencing from the purely combinational opcode decode.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles on imem_ready/dmem_ready before a fault; 0 disables the timeout.
- CNT_W, 16: width of retire_count.
- clk  in  1  core clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  leave IDLE and begin fetching.
- halt  in  1  stop at the next instruction boundary.
- clear_fault  in  1  leave FAULT and return to IDLE.
- opcode  in  7  instruction[6:0] from the IR; valid from DECODE onward.
- branch_taken  in  1  branch comparison result; valid in EXECUTE.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load the IR.
- pc_load  out  1  update the PC.
- pc_sel  out  1  PC source: 0 = PC+4, 1 = branch target.
- rf_read_en  out  1  register file read.
- alu_en  out  1  ALU operate.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write.
- rf_write_en  out  1  register file write.
- wb_sel  out  1  writeback source: 0 = ALU, 1 = memory.
- cg_en  out  4  clock-gate enables: [0] fetch, [1] regfile, [2] ALU, [3] dmem.
- busy  out  1  high in any state except IDLE and FAULT.
- fault  out  1  high in FAULT.
- retire_count  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, FAULT. Reset: state = IDLE, every output 0, retire_count = 0.
- IDLE: start=1 → FETCH.
- FETCH: imem_req=1, cg_en[0]=1.
  - imem_ready=1 → ir_load=1 in the same cycle, then DECODE.
- DECODE: rf_read_en=1, cg_en[1]=1. opcode is latched into op_q.
  - Known opcodes 0110011, 0000011, 0100011, 1100011 → EXECUTE.
  - Any other opcode is a NOP: pc_load=1, pc_sel=0, retire.
- EXECUTE: alu_en=1, cg_en[2]=1.
  - R-type → WB.
  - Load or store → MEM.
  - Branch: pc_load=1, pc_sel=branch_taken, retire.
- MEM: dmem_req=1, dmem_we=(op_q is store), cg_en[3]=1.
  - dmem_ready=1 with load → WB.
  - dmem_ready=1 with store: pc_load=1, pc_sel=0, retire.
- WB: rf_write_en=1, wb_sel=(op_q is load), cg_en[1]=1, pc_load=1, pc_sel=0, retire.
- Retire is an instruction boundary: retire_count increments and the next state is FETCH, or IDLE if halt=1 in that cycle.
- Timeout: wait_cnt (width clog2(MEM_TIMEOUT+1)) clears on entry to FETCH or MEM and counts cycles with ready low.
  - Ready low when wait_cnt == MEM_TIMEOUT-1 → FAULT. A wait therefore faults after exactly MEM_TIMEOUT cycles without ready.
  - In FAULT all strobes and cg_en are 0. FAULT holds until clear_fault=1, then IDLE. retire_count is preserved.
- Input precedence:
  - start is ignored outside IDLE.
  - halt is honoured only at retire.
  - clear_fault is ignored outside FAULT.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial writeback.

## Timing
- Outputs are decoded from the state register. ir_load and pc_load are additionally gated by the same-cycle ready, branch and opcode conditions.
- cg_en is a pure function of the state register and is 0 in IDLE and FAULT.
- Cycles per instruction with zero-wait memories: R-type 4, load 5, store 4, branch 3, unknown opcode 2. Each ready-low cycle adds 1.
- retire_count updates on the clock edge that ends the retiring cycle.

## Test plan
- Reset then start, R-type (0110011), imem_ready=1: states FETCH/DECODE/EXECUTE/WB; rf_write_en=1 and wb_sel=0 in cycle 4; retire_count=1; back in FETCH on cycle 5.
- Load (0000011) with dmem_ready low for 2 cycles: MEM lasts 3 cycles, WB has wb_sel=1, total 7 cycles, no fault.
- Branch (1100011): branch_taken=1 → pc_sel=1 and pc_load=1 in EXECUTE; repeat with branch_taken=0 → pc_sel=0; 3 cycles each.
- Store (0100011) with dmem_ready held 0 and MEM_TIMEOUT=15: FAULT entered after 15 MEM cycles, all strobes 0, busy=0. clear_fault → IDLE; retire_count unchanged.
- halt=1 during WB of an R-type: next state IDLE, busy=0. Then opcode 1111111: DECODE retires as a NOP in 2 cycles with pc_sel=0.
- rst_n pulsed low during MEM: all outputs 0 asynchronously, retire_count=0. After release the block stays in IDLE until start.
